clock_monitor: RTL and testbench
================================

// Module: clock_monitor
// PURPOSE
//   Fast-domain consumer of a divided clock, such as the output of our clock divider.
//   It resynchronises the slow clock into clk and emits one-cycle rise/fall strobes.
//   It measures the slow-clock period in clk cycles and flags loss of the slow clock.
//   Sits directly downstream of the divider: gates slow-rate logic by strobe, and supports self-test.
// PARAMETERS
//   SYNC_STAGES   2      synchroniser depth on clk_in (legal: >=2)
//   PERIOD_WIDTH  16     width of period counter/output
//   TIMEOUT       1000   clk cycles with no clk_in edge before lost asserts (legal: 1..2**PERIOD_WIDTH-2)
// PORTS
//   clk           in   1             system clock; all logic on posedge clk
//   rst           in   1             asynchronous, active-high reset
//   clk_in        in   1             slow/divided clock, treated as asynchronous data
//   rise          out  1             one-cycle strobe per synchronised rising edge of clk_in
//   fall          out  1             one-cycle strobe per synchronised falling edge of clk_in
//   period        out  PERIOD_WIDTH  clk cycles between the last two rises (saturating)
//   period_valid  out  1             period holds a valid measurement
//   lost          out  1             no clk_in edge for TIMEOUT cycles
// BEHAVIOUR
//   Reset (async, immediate, also mid-operation):
//     - sync chain = 0; rise = fall = 0; period = 0; period_valid = 0; lost = 0.
//     - state = WAIT_FIRST; cycle and timeout counters = 0.
//   Sync/edge:
//     - clk_in passes SYNC_STAGES flops, then one history flop.
//     - rise = s & ~s_d; fall = ~s & s_d; both registered outputs.
//     - Latency is SYNC_STAGES+1 clk cycles from clk_in transition to strobe.
//     - A first sample of 1 after reset counts as a rise (history resets to 0).
//   Period counter (cnt, PERIOD_WIDTH bits):
//     - Loaded with 1 in the cycle a rise is detected.
//     - Otherwise increments each cycle, saturating at all-ones (no wrap).
//     - On a rise while in MEASURE or LOCKED: period <= cnt (pre-load value), same cycle as rise.
//       Example: clk_in period 4 clk cycles gives period = 4.
//   Timeout counter:
//     - Cleared on any rise or fall; else increments while state != LOST and != WAIT_FIRST.
//     - Reaching TIMEOUT triggers LOST.
//   FSM:
//     - WAIT_FIRST: rise -> MEASURE. No timeout is armed in this state; lost stays 0.
//     - MEASURE: rise -> LOCKED (period captured, period_valid <= 1); timeout -> LOST.
//     - LOCKED: rise -> LOCKED (period updated each rise); timeout -> LOST.
//     - LOST: lost = 1, period_valid = 0, period holds last value.
//       rise -> MEASURE, and lost clears in the same cycle.
//   Simultaneous events:
//     - rise and timeout in the same cycle: rise wins, no LOST entry.
//     - A fall alone refreshes the timeout but never captures period.
//   Output timing:
//     - period and period_valid update in the same cycle the rise strobe is high.
//     - lost asserts in the cycle after the timeout counter reaches TIMEOUT.
// TESTING
//   1 rst pulse mid-run while LOCKED:
//     - all outputs 0 within the same cycle, with no clk edge needed.
//     - Next two rises give period_valid = 1 again.
//   2 clk_in = clk/4 (2 high, 2 low), SYNC_STAGES = 2:
//     - rise/fall alternate every 2 cycles, each exactly 1 cycle wide.
//     - After the 2nd rise, period = 4 and period_valid = 1.
//   3 Drive clk_in as clk/10, then switch to clk/6 on the fly:
//     - period reads 10, then 6 from the first full new period onward. No glitch strobes.
//   4 TIMEOUT = 20, clk_in held at 1 after LOCKED:
//     - lost = 1 and period_valid = 0 after 20 quiet cycles (+1).
//     - Restarting clk/4 clears lost on the first rise; period_valid returns after the next rise.
//   5 PERIOD_WIDTH = 4, TIMEOUT = 14, clk_in period 14:
//     - period = 14, no lost.
//     - Hold clk_in high -> lost after 14; cnt saturates at 15, never wraps to 0.
//   6 clk_in toggled 1 cycle after reset deassert, at sync-edge timing:
//     - exactly one rise, no double strobe, state = MEASURE, lost = 0.

Source files
------------

// File: rtl/clock_monitor.sv
// Resynchronises a slow/divided clock into clk, emits rise/fall strobes,
// measures the slow-clock period in clk cycles and flags loss of the slow clock.
module clock_monitor #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned TIMEOUT      = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_in,
  output logic                    rise,
  output logic                    fall,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    lost
);

  typedef enum logic [1:0] {StWaitFirst, StMeasure, StLocked, StLost} state_e;

  localparam logic [PERIOD_WIDTH-1:0] CntMax     = '1;
  localparam logic [PERIOD_WIDTH-1:0] CntOne     = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] TimeoutVal = PERIOD_WIDTH'(TIMEOUT);

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    hist_q, hist_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] tmo_q, tmo_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    valid_q, valid_d;
  logic                    lost_q, lost_d;
  state_e                  state_q, state_d;

  logic s;
  logic tmo_hit;

  // Synchroniser, history flop and edge detection
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], clk_in};
    s      = sync_q[SYNC_STAGES-1];
    hist_d = s;
    rise_d = s & ~hist_q;
    fall_d = ~s & hist_q;
  end

  // Period counter restarts at 1 on each rise and saturates instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (rise_d) begin
      cnt_d = CntOne;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Timeout counter is frozen while waiting for the first rise and once lost
  always_comb begin
    tmo_d = tmo_q;
    if (rise_d || fall_d) begin
      tmo_d = '0;
    end else if (state_q != StLost && state_q != StWaitFirst) begin
      tmo_d = tmo_q + CntOne;
    end
  end

  assign tmo_hit = (tmo_q >= TimeoutVal);

  // A rise always takes priority over a timeout in the same cycle
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    valid_d  = valid_q;
    lost_d   = lost_q;
    unique case (state_q)
      StWaitFirst: begin
        if (rise_d) begin
          state_d = StMeasure;
        end
      end
      StMeasure, StLocked: begin
        if (rise_d) begin
          state_d  = StLocked;
          period_d = cnt_q;
          valid_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d = StLost;
          lost_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      StLost: begin
        if (rise_d) begin
          state_d = StMeasure;
          lost_d  = 1'b0;
        end
      end
      default: state_d = StWaitFirst;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      state_q  <= StWaitFirst;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
      state_q  <= state_d;
    end
  end

  assign rise         = rise_q;
  assign fall         = fall_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor: two instances (wide/narrow counters) share one
// clk_in stream and are compared every cycle against an event-level reference model.
module tb_clock_monitor;

  localparam int SYNC = 2;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        clk_in = 1'b0;

  logic        rise_a, fall_a, pv_a, lost_a;
  logic [15:0] period_a;
  logic        rise_b, fall_b, pv_b, lost_b;
  logic [3:0]  period_b;

  clock_monitor #(
    .SYNC_STAGES (SYNC),
    .PERIOD_WIDTH(16),
    .TIMEOUT     (20)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .clk_in      (clk_in),
    .rise        (rise_a),
    .fall        (fall_a),
    .period      (period_a),
    .period_valid(pv_a),
    .lost        (lost_a)
  );

  clock_monitor #(
    .SYNC_STAGES (SYNC),
    .PERIOD_WIDTH(4),
    .TIMEOUT     (14)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .clk_in      (clk_in),
    .rise        (rise_b),
    .fall        (fall_b),
    .period      (period_b),
    .period_valid(pv_b),
    .lost        (lost_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sample history plus per-instance event bookkeeping.
  // State: 0 wait-first, 1 measure, 2 locked, 3 lost.
  int samp[$];
  int n;
  int erise, efall;
  int st[2], lrise[2], levt[2], eper[2], epv[2], elost[2];
  int to_lim[2]  = '{20, 14};
  int per_max[2] = '{65535, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int smp(input int j);
    if (j < 1) return 0;
    return samp[j-1];
  endfunction

  task automatic model_reset();
    samp.delete();
    n     = 0;
    erise = 0;
    efall = 0;
    for (int d = 0; d < 2; d++) begin
      st[d]    = 0;
      lrise[d] = 0;
      levt[d]  = 0;
      eper[d]  = 0;
      epv[d]   = 0;
      elost[d] = 0;
    end
  endtask

  task automatic model_edge(input int v);
    int sc, sp;
    samp.push_back(v);
    n++;
    // Strobe at edge n reflects the input stream delayed by SYNC+1 samples
    sc    = smp(n - SYNC);
    sp    = smp(n - SYNC - 1);
    erise = (sc == 1 && sp == 0) ? 1 : 0;
    efall = (sc == 0 && sp == 1) ? 1 : 0;
    for (int d = 0; d < 2; d++) begin
      if (erise == 1) begin
        if (st[d] == 1 || st[d] == 2) begin
          eper[d] = (n - lrise[d] > per_max[d]) ? per_max[d] : n - lrise[d];
          epv[d]  = 1;
          st[d]   = 2;
        end else begin
          st[d]    = 1;
          elost[d] = 0;
        end
        lrise[d] = n;
        levt[d]  = n;
      end else begin
        if ((st[d] == 1 || st[d] == 2) && (n - levt[d] >= to_lim[d] + 1)) begin
          st[d]    = 3;
          elost[d] = 1;
          epv[d]   = 0;
        end
        if (efall == 1) levt[d] = n;
      end
    end
  endtask

  task automatic cyc(input int v);
    clk_in = v[0];
    @(posedge clk);
    model_edge(v);
    #1;
    chk("rise_a", 32'(rise_a), erise);
    chk("fall_a", 32'(fall_a), efall);
    chk("period_a", 32'(period_a), eper[0]);
    chk("valid_a", 32'(pv_a), epv[0]);
    chk("lost_a", 32'(lost_a), elost[0]);
    chk("rise_b", 32'(rise_b), erise);
    chk("fall_b", 32'(fall_b), efall);
    chk("period_b", 32'(period_b), eper[1]);
    chk("valid_b", 32'(pv_b), epv[1]);
    chk("lost_b", 32'(lost_b), elost[1]);
  endtask

  task automatic run(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc(1);
      for (int i = 0; i < lo; i++) cyc(0);
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rise", 32'({rise_a, rise_b}), 0);
    chk("rst_fall", 32'({fall_a, fall_b}), 0);
    chk("rst_period", 32'({period_a, period_b}), 0);
    chk("rst_valid", 32'({pv_a, pv_b}), 0);
    chk("rst_lost", 32'({lost_a, lost_b}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // clk/4
    run(2, 2, 6);
    chk("div4_period", 32'(period_a), 4);
    chk("div4_valid", 32'(pv_a), 1);

    // clk/10 switching to clk/6 on the fly
    run(5, 5, 4);
    chk("div10_period", 32'(period_a), 10);
    run(3, 3, 4);
    chk("div6_period", 32'(period_a), 6);

    // Stall high: both instances time out
    for (int i = 0; i < 25; i++) cyc(1);
    chk("stall_lost_a", 32'(lost_a), 1);
    chk("stall_valid_a", 32'(pv_a), 0);
    chk("stall_period_a", 32'(period_a), 6);
    chk("stall_lost_b", 32'(lost_b), 1);
    for (int i = 0; i < 2; i++) cyc(0);
    run(2, 2, 3);
    chk("restart_lost_a", 32'(lost_a), 0);
    chk("restart_valid_a", 32'(pv_a), 1);

    // Period equal to the narrow instance's timeout, then saturation
    run(7, 7, 4);
    chk("p14_period_b", 32'(period_b), 14);
    chk("p14_lost_b", 32'(lost_b), 0);
    for (int i = 0; i < 20; i++) cyc(1);
    chk("hold_lost_b", 32'(lost_b), 1);
    for (int i = 0; i < 2; i++) cyc(0);
    run(10, 10, 4);
    chk("sat_period_b", 32'(period_b), 15);
    chk("p20_period_a", 32'(period_a), 20);

    // Reset mid-run while locked, then relock
    run(2, 2, 3);
    do_reset();
    run(2, 2, 4);
    chk("relock_valid_a", 32'(pv_a), 1);

    // Input goes high right after reset: exactly one rise, measure state
    do_reset();
    cyc(0);
    for (int i = 0; i < 8; i++) cyc(1);
    chk("first_valid_a", 32'(pv_a), 0);
    chk("first_lost_a", 32'(lost_a), 0);

    // Random duty cycles with occasional long stalls
    for (int k = 0; k < 80; k++) begin
      int hi, lo;
      hi = int'($urandom_range(1, 12));
      lo = int'($urandom_range(1, 12));
      if ($urandom_range(0, 9) == 0) hi = 30;
      if ($urandom_range(0, 9) == 0) lo = 30;
      run(hi, lo, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
